// File: rtl/conv1_pixel_streamer_if.sv
// Pixel stream carrying one image beat plus its row/frame boundary flags.
// The master drives data and flags, and the slave returns ready.
interface conv1_pixel_streamer_if #(
  parameter int DATA_BITS = 8
);
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_row_last;
  logic                 out_frame_last;

  modport master (
    output out_valid, out_data, out_row_last, out_frame_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row_last, out_frame_last,
    output out_ready
  );
endinterface

// File: rtl/conv1_pixel_streamer.sv
// Frame buffer for one square image. It replays the stored pixels as a raster stream into conv1's line buffer.
// A two-entry skid FIFO behind the registered RAM read sustains one beat per clock.
module conv1_pixel_streamer #(
  parameter int DATA_BITS  = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int GAP_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [9:0]           wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_drop,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  conv1_pixel_streamer_if.master out_if
);

  localparam int              NPIX     = IMG_WIDTH * IMG_WIDTH;
  localparam int              CW       = $clog2(IMG_WIDTH);
  localparam logic [9:0]      NPIX_L   = 10'(NPIX);
  localparam logic [9:0]      LAST_IDX = 10'(NPIX - 1);
  localparam logic [CW-1:0]   LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [3:0]      GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t state_q, state_d;

  logic [DATA_BITS-1:0] mem [NPIX];
  logic [DATA_BITS-1:0] ram_q;
  logic                 ram_vld, ram_rl, ram_fl;

  logic [1:0][DATA_BITS-1:0] fifo_data;
  logic [1:0]                fifo_rl, fifo_fl;
  logic                      wr_ptr, rd_ptr;
  logic [1:0]                count;

  logic [9:0]    rd_idx;
  logic [CW-1:0] rd_col;
  logic          issue_done;
  logic [3:0]    gap_cnt;

  logic       wr_ok, wr_bad, rd_en, pop, push, head_rl, head_fl;
  logic [2:0] occ_next;

  assign wr_ok  = wr_en && (state_q == IDLE) && (wr_addr < NPIX_L);
  assign wr_bad = wr_en && !wr_ok;
  assign busy   = (state_q != IDLE);

  assign out_if.out_valid      = (state_q == STREAM) && (count != 2'd0);
  assign out_if.out_data       = fifo_data[rd_ptr];
  assign out_if.out_row_last   = fifo_rl[rd_ptr];
  assign out_if.out_frame_last = fifo_fl[rd_ptr];

  assign head_rl = fifo_rl[rd_ptr];
  assign head_fl = fifo_fl[rd_ptr];
  assign pop     = out_if.out_valid && out_if.out_ready;
  assign push    = ram_vld;

  // A read is issued only if its data still fits in the FIFO. This assumes no pop on the cycle the data lands.
  assign occ_next = {1'b0, count} + {2'b0, ram_vld} - {2'b0, pop};
  assign rd_en    = (state_q != IDLE) && !issue_done && (occ_next <= 3'd1);

  // NOTE: storage has no reset; contents survive rst_n and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    if (rd_en) ram_q <= mem[rd_idx];
  end

  // NOTE: every combinational output gets its default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = STREAM;
      STREAM: begin
        if (pop && head_fl)                          state_d = IDLE;
        else if (pop && head_rl && GAP_CYCLES > 0)   state_d = GAP;
      end
      GAP:    if (gap_cnt == 4'd0) state_d = STREAM;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments only, so every register reads pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      done       <= 1'b0;
      wr_drop    <= 1'b0;
      rd_idx     <= '0;
      rd_col     <= '0;
      issue_done <= 1'b0;
      ram_vld    <= 1'b0;
      ram_rl     <= 1'b0;
      ram_fl     <= 1'b0;
      fifo_data  <= '0;
      fifo_rl    <= '0;
      fifo_fl    <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= '0;
      gap_cnt    <= '0;
    end else begin
      state_q <= state_d;
      done    <= pop && head_fl;
      wr_drop <= wr_bad;

      if (state_q == IDLE && start) begin
        rd_idx     <= '0;
        rd_col     <= '0;
        issue_done <= 1'b0;
      end else if (rd_en) begin
        issue_done <= (rd_idx == LAST_IDX);
        if (rd_idx != LAST_IDX) rd_idx <= rd_idx + 10'd1;
        rd_col <= (rd_col == LAST_COL) ? '0 : rd_col + CW'(1);
      end

      ram_vld <= rd_en;
      if (rd_en) begin
        ram_rl <= (rd_col == LAST_COL);
        ram_fl <= (rd_idx == LAST_IDX);
      end

      if (push) begin
        fifo_data[wr_ptr] <= ram_q;
        fifo_rl[wr_ptr]   <= ram_rl;
        fifo_fl[wr_ptr]   <= ram_fl;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};

      if (state_q == STREAM && state_d == GAP) gap_cnt <= GAP_LOAD;
      else if (state_q == GAP && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_conv1_pixel_streamer.sv
// Checks two streamers, one with no row gap and one with GAP_CYCLES=3, against a raster model of the stored image.
// Ready patterns include fixed, 1001 and random back-pressure.
module tb_conv1_pixel_streamer;
  localparam int W = 28;
  localparam int N = W * W;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0, we_both = 1'b1;
  logic [9:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0, rdy = 1'b1, sel = 1'b0;
  logic       wr_en0, wr_en3, start0, start3;
  logic       wr_drop0, wr_drop3, busy0, busy3, done0, done3;
  logic       v, rl, fl, bz, dn, wd;
  logic [7:0] d;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] ref_mem [N];

  always #5 clk = ~clk;

  conv1_pixel_streamer_if #(.DATA_BITS(8)) if0 ();
  conv1_pixel_streamer_if #(.DATA_BITS(8)) if3 ();

  assign wr_en0 = we && (we_both || !sel);
  assign wr_en3 = we && (we_both || sel);
  assign start0 = start && !sel;
  assign start3 = start && sel;
  assign if0.out_ready = rdy;
  assign if3.out_ready = rdy;

  conv1_pixel_streamer #(.DATA_BITS(8), .IMG_WIDTH(W), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_drop(wr_drop0), .start(start0), .busy(busy0), .done(done0), .out_if(if0));

  conv1_pixel_streamer #(.DATA_BITS(8), .IMG_WIDTH(W), .GAP_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en3), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_drop(wr_drop3), .start(start3), .busy(busy3), .done(done3), .out_if(if3));

  assign v  = sel ? if3.out_valid      : if0.out_valid;
  assign d  = sel ? if3.out_data       : if0.out_data;
  assign rl = sel ? if3.out_row_last   : if0.out_row_last;
  assign fl = sel ? if3.out_frame_last : if0.out_frame_last;
  assign bz = sel ? busy3    : busy0;
  assign dn = sel ? done3    : done0;
  assign wd = sel ? wr_drop3 : wr_drop0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic write_px(input logic [9:0] a, input logic [7:0] x);
    we = 1'b1; wr_addr = a; wr_data = x;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic load_frame(input bit rnd);
    logic [7:0] x;
    for (int i = 0; i < N; i++) begin
      x = rnd ? 8'($urandom) : 8'(i % 256);
      ref_mem[i] = x;
      write_px(10'(i), x);
    end
  endtask

  // Plays one frame on the selected DUT. The caller enters on a negedge, and the task returns on one.
  task automatic run_frame(input bit s, input int rmode, input int gap, input int abort_at,
                           input bit mid_start, input bit mid_write,
                           input bit chain_pre, input bit chain_next);
    int k = 0, n = 0, idle = 0, busy_cnt = 0;
    bit fin = 0, hold = 0, seen_v = 0, ms_done = 0, mw_done = 0;
    logic [7:0] pd = '0;
    logic prl = 1'b0, pfl = 1'b0;
    logic [3:0] pat = 4'b1001;
    sel = s;
    if (!chain_pre) start = 1'b1;
    @(negedge clk);
    start = 1'b0; we = 1'b0; n = 1;
    check("busy_after_start", 32'(bz), 32'd1);
    while (!fin && n < 4000) begin
      start = 1'b0;
      if (we) begin
        check("wr_drop_busy", 32'(wd), 32'd1);
        we = 1'b0; we_both = 1'b1;
      end
      if (bz) busy_cnt++;
      if (hold) begin
        check("hold_valid", 32'(v), 32'd1);
        check("hold_data", 32'(d), 32'(pd));
        check("hold_flags", 32'({rl, fl}), 32'({prl, pfl}));
      end
      if (v && !seen_v) begin
        seen_v = 1;
        check("first_valid_latency", 32'(n), 32'd3);
      end
      check("done_low_midframe", 32'(dn), 32'd0);
      if (abort_at >= 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(v), 32'd0);
        check("abort_busy", 32'(bz), 32'd0);
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", 32'(dn), 32'd0);
        end
        rst_n = 1'b1;
        return;
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = pat[n % 4];
        default: rdy = 1'($urandom);
      endcase
      if (mid_start && k >= 100 && !ms_done) begin start = 1'b1; ms_done = 1; end
      if (mid_write && k >= 200 && !mw_done) begin
        we_both = 1'b0; we = 1'b1; wr_addr = 10'd5; wr_data = 8'hAA; mw_done = 1;
      end
      if (v && rdy) begin
        check("beat_data", 32'(d), 32'(ref_mem[k]));
        check("beat_row_last", 32'(rl), 32'(k % W == W - 1));
        check("beat_frame_last", 32'(fl), 32'(k == N - 1));
        if (rmode == 0 && k > 0)
          check("idle_before_beat", 32'(idle), 32'((k % W == 0) ? gap : 0));
        idle = 0;
        k++;
        if (k == N) fin = 1;
      end else if (!v && seen_v) begin
        idle++;
      end
      hold = v && !rdy; pd = d; prl = rl; pfl = fl;
      @(negedge clk);
      n++;
    end
    rdy = 1'b1;
    if (!fin) begin
      check("frame_timeout_beats", 32'(k), 32'(N));
      return;
    end
    check("end_valid_low", 32'(v), 32'd0);
    check("end_busy_low", 32'(bz), 32'd0);
    check("end_done_pulse", 32'(dn), 32'd1);
    if (rmode == 0) check("busy_span", 32'(busy_cnt), 32'(N + 2 + (W - 1) * gap));
    if (chain_next) begin
      start = 1'b1;
    end else begin
      @(negedge clk);
      check("done_one_cycle", 32'(dn), 32'd0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(if0.out_valid), 32'd0);
    check("rst_valid3", 32'(if3.out_valid), 32'd0);
    check("rst_busy_done_drop", 32'({busy0, done0, wr_drop0}), 32'd0);
    check("rst_data_flags", 32'({if0.out_data, if0.out_row_last, if0.out_frame_last}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    load_frame(1'b0);
    check("good_write_no_drop", 32'(wd), 32'd0);
    run_frame(0, 0, 0, -1, 0, 0, 0, 0);
    run_frame(0, 1, 0, -1, 0, 0, 0, 0);
    run_frame(1, 0, 3, -1, 0, 0, 0, 0);
    run_frame(1, 2, 3, -1, 0, 0, 0, 0);

    run_frame(0, 2, 0, -1, 0, 1, 0, 0);
    sel = 1'b0;
    write_px(10'd800, 8'h55);
    check("wr_drop_range", 32'(wd), 32'd1);
    @(negedge clk);
    check("wr_drop_one_cycle", 32'(wd), 32'd0);

    run_frame(0, 0, 0, -1, 1, 0, 0, 1);
    run_frame(0, 2, 0, -1, 0, 0, 1, 0);

    ref_mem[0] = 8'($urandom);
    we = 1'b1; wr_addr = 10'd0; wr_data = ref_mem[0]; start = 1'b1;
    run_frame(0, 0, 0, -1, 0, 0, 1, 0);

    run_frame(0, 0, 0, 400, 0, 0, 0, 0);
    @(negedge clk);
    run_frame(0, 0, 0, -1, 0, 0, 0, 0);

    load_frame(1'b1);
    run_frame(0, 2, 0, -1, 0, 0, 0, 0);
    run_frame(1, 2, 3, -1, 0, 0, 0, 0);
    run_frame(1, 0, 3, -1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/conv1_pixel_streamer.md
Name: conv1_pixel_streamer

Overview:
- Frame-buffer source that feeds conv1's sliding-window line buffer.
- A loader (UART/testbench/host) writes one 28x28 8-bit image into on-chip storage. A start pulse then replays it as a raster pixel stream, row 0 col 0 first.
- Output is a valid/ready stream; optional inter-row gaps exercise the consumer's stall tolerance.
- Signals frame completion to the top-level controller.

Parameters:
- DATA_BITS, 8, pixel width.
- IMG_WIDTH, 28, pixels per row and rows per frame (square image).
- GAP_CYCLES, 0, idle cycles inserted between the last beat of a row and the first beat of the next row (0..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  loader write strobe.
- wr_addr  input  10  pixel address, row*IMG_WIDTH+col.
- wr_data  input  DATA_BITS  pixel value.
- wr_drop  output  1  one-cycle pulse: write rejected.
- start  input  1  begin streaming the stored frame.
- busy  output  1  streaming in progress.
- done  output  1  one-cycle pulse after the final beat is accepted.
- out_valid  output  1  out_data holds a pixel.
- out_ready  input  1  consumer accepts the beat; tie to 1 for conv1 line buffer input.
- out_data  output  DATA_BITS  pixel value.
- out_row_last  output  1  current beat is col IMG_WIDTH-1.
- out_frame_last  output  1  current beat is pixel IMG_WIDTH*IMG_WIDTH-1.

Behaviour:
- Reset (async assert, sync release): state IDLE; pixel counter 0; gap counter 0.
- All outputs reset to 0: busy, done, wr_drop, out_valid, out_data, out_row_last, out_frame_last.
- Memory contents are not reset.
- Storage: IMG_WIDTH*IMG_WIDTH entries with 1-cycle registered read. Infer as block/distributed RAM; no reset loop.
- Writes:
  - Committed when wr_en=1, state IDLE and wr_addr < IMG_WIDTH*IMG_WIDTH.
  - If wr_en=1 while busy, or with wr_addr out of range: nothing written; wr_drop=1 the next cycle.
- State machine IDLE -> STREAM <-> GAP -> IDLE.
- IDLE:
  - start=1 sampled at edge T: busy=1 from T+1; first beat (pixel 0) out_valid=1 at T+2.
  - A write in the same cycle as start is committed and is visible to the stream.
- Handshake:
  - A beat transfers when out_valid&&out_ready.
  - While out_ready=0, out_valid, out_data and the flags hold stable; out_valid never drops without a transfer.
  - With out_ready held 1 and GAP_CYCLES=0: one beat per cycle, 784 consecutive cycles. This requires prefetch/skid, which must hide the RAM latency.
- Flags:
  - out_row_last=1 with every beat whose col = IMG_WIDTH-1.
  - out_frame_last=1 only with pixel 783; out_row_last is also 1 on that beat.
- GAP:
  - Entered after a row-last beat transfers, except after the frame-last beat, and only if GAP_CYCLES>0.
  - out_valid=0 for exactly GAP_CYCLES cycles, then the next row's col 0 beat is valid.
- Frame end: final beat transfers at edge E. Then out_valid=0, busy=0, done=1 (one cycle) at E+1. start is accepted again from E+1.
- start while busy is ignored; no restart, no error.
- Counters: 10-bit pixel index, no wrap past 783. Row/col derived by 5-bit counters, col wraps at IMG_WIDTH-1.
- Reset mid-frame: immediate abort, outputs to reset values, no done pulse.

Test Plan:
1. Load pixel[i]=i mod 256 for i=0..783; start; out_ready=1, GAP=0 -> first out_valid 2 cycles after start, 784 consecutive beats with values 0,1,..,255,0..; out_row_last at beats 27,55,..,783; out_frame_last only at beat 783; done 1 cycle after; busy low same cycle.
2. Same frame, out_ready toggling 1,0,0,1 pattern -> identical 784-value sequence; out_data stable during every out_ready=0 cycle; no beat lost or duplicated.
3. GAP_CYCLES=3, out_ready=1 -> exactly 3 idle cycles after each of the first 27 row-last beats; none after beat 783; total busy span 784+81 beats plus latency.
4. wr_en during busy with addr 5, data 0xAA -> wr_drop pulse; pixel 5 unchanged on the next frame. wr_addr=800 in IDLE -> wr_drop, no write.
5. start re-asserted mid-frame -> ignored; stream continues unchanged. start asserted the cycle done pulses -> second frame starts normally.
6. rst_n low at beat 400 -> out_valid/busy clear asynchronously, no done. After release, start -> streaming restarts from pixel 0 with the memory contents intact.
